// File: rtl/idli_de_m.sv
// Decode: assembles LS-first nibbles into a 16b insn (+ optional 16b imm); IDLI_DE_ILLEGAL_EN traps opcode F.
// Latency: op valid the cycle after its final nibble is accepted; one op per 4 (or 8 with imm) nibbles.
// Backpressure: only the completing nibble stalls, while a held op is not accepted; flush always ready.
module idli_de_m #(
    parameter logic [3:0] IMM_REG = 4'hF
) (
    input  logic        i_de_gck,
    input  logic        i_ex_rst_n,
    input  logic        i_de_flush,
    input  logic [3:0]  i_de_nib,
    input  logic        i_de_nib_vld,
    output logic        o_de_nib_rdy,
    output logic [3:0]  o_de_op_opc,
    output logic [3:0]  o_de_op_a,
    output logic [3:0]  o_de_op_b,
    output logic [3:0]  o_de_op_c,
    output logic        o_de_op_imm_vld,
    output logic [15:0] o_de_op_imm,
    output logic        o_de_op_vld,
    input  logic        i_de_op_acp,
    output logic        o_de_op_ill
);

    typedef enum logic {ST_INSN = 1'b0, ST_IMM = 1'b1} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [15:0] insn;      // shift register, newest nibble enters at the top
    logic [11:0] imm_sr;
    logic        nib_ill;
    logic        last_pos;
    logic        nib_xfer;
    logic        complete;
    logic        op_xfer;

`ifdef IDLI_DE_ILLEGAL_EN
    // The opcode is the final insn nibble, so illegality is known as it arrives.
    assign nib_ill = (state == ST_INSN) && (i_de_nib == 4'hF);

    always_ff @(posedge i_de_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            o_de_op_ill <= 1'b0;
        end else if (complete) begin
            o_de_op_ill <= nib_ill;
        end
    end
`else
    assign nib_ill     = 1'b0;
    assign o_de_op_ill = 1'b0;
`endif

    // At insn count 3, field B (nibble 1) sits in insn[11:8] after three shifts.
    assign last_pos     = (cnt == 2'd3) &&
                          ((state == ST_IMM) || (insn[11:8] != IMM_REG) || nib_ill);
    assign o_de_nib_rdy = i_de_flush || !(last_pos && o_de_op_vld && !i_de_op_acp);
    assign nib_xfer     = i_de_nib_vld && o_de_nib_rdy && !i_de_flush;
    assign complete     = nib_xfer && last_pos;
    assign op_xfer      = o_de_op_vld && i_de_op_acp;

    always_ff @(posedge i_de_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            state           <= ST_INSN;
            cnt             <= 2'd0;
            insn            <= 16'h0;
            imm_sr          <= 12'h0;
            o_de_op_vld     <= 1'b0;
            o_de_op_opc     <= 4'h0;
            o_de_op_a       <= 4'h0;
            o_de_op_b       <= 4'h0;
            o_de_op_c       <= 4'h0;
            o_de_op_imm_vld <= 1'b0;
            o_de_op_imm     <= 16'h0;
        end else if (i_de_flush) begin
            state       <= ST_INSN;
            cnt         <= 2'd0;
            o_de_op_vld <= 1'b0;
        end else begin
            if (nib_xfer) begin
                cnt <= cnt + 2'd1;
                if (state == ST_INSN) begin
                    insn <= {i_de_nib, insn[15:4]};
                    if (cnt == 2'd3 && !last_pos) begin
                        state <= ST_IMM;
                    end
                end else begin
                    imm_sr <= {i_de_nib, imm_sr[11:4]};
                    if (cnt == 2'd3) begin
                        state <= ST_INSN;
                    end
                end
            end

            if (complete) begin
                o_de_op_vld <= 1'b1;
                if (state == ST_INSN) begin
                    {o_de_op_opc, o_de_op_a, o_de_op_b, o_de_op_c} <= {i_de_nib, insn[15:4]};
                    o_de_op_imm_vld <= 1'b0;
                    o_de_op_imm     <= 16'h0;
                end else begin
                    {o_de_op_opc, o_de_op_a, o_de_op_b, o_de_op_c} <= insn;
                    o_de_op_imm_vld <= 1'b1;
                    o_de_op_imm     <= {i_de_nib, imm_sr};
                end
            end else if (op_xfer) begin
                o_de_op_vld <= 1'b0;
            end
        end
    end

endmodule

// File: doc/idli_de_m.md
Name: idli_de_m

Overview:
- Decode stage sitting directly upstream of the execution stage.
- Receives instructions from fetch as 4b nibbles, least-significant nibble first, and assembles 16b instruction words.
- Optionally collects a trailing 16b immediate.
- Presents a fully decoded op to execution through a valid/accept handshake. Execution's accept may be high with no valid op.

Parameters:
- IMM_REG, 4'hF, register index in field B that marks "operand B is a trailing 16b immediate".

Ports:
- i_de_gck  input  1  clock (same domain as execution).
- i_ex_rst_n  input  1  reset, asynchronous, active-low.
- i_de_flush  input  1  discard partial and held instruction.
- i_de_nib  input  4  instruction/immediate nibble from fetch.
- i_de_nib_vld  input  1  i_de_nib valid.
- o_de_nib_rdy  output  1  decode can take i_de_nib this cycle.
- o_de_op_opc  output  4  opcode, instruction bits [15:12].
- o_de_op_a  output  4  field A, bits [11:8].
- o_de_op_b  output  4  field B, bits [7:4].
- o_de_op_c  output  4  field C, bits [3:0].
- o_de_op_imm_vld  output  1  op carries an immediate.
- o_de_op_imm  output  16  immediate value; 0 when o_de_op_imm_vld=0.
- o_de_op_vld  output  1  decoded op valid.
- i_de_op_acp  input  1  execution accepts; transfer = o_de_op_vld && i_de_op_acp.
- o_de_op_ill  output  1  illegal opcode (optional feature only; tied 0 otherwise).

Behaviour:
- Nibble transfer occurs when i_de_nib_vld && o_de_nib_rdy.
- Assembly FSM states:
  - INSN: 2b counter 0..3; nibble k is written to instruction bits [4k+3:4k].
  - IMM: 2b counter 0..3; nibble k is written to immediate bits [4k+3:4k].
- Transitions:
  - INSN, count 3 transfer, B != IMM_REG: op completes; stay in INSN, counter wraps to 0.
  - INSN, count 3 transfer, B == IMM_REG: go to IMM, counter 0.
  - IMM, count 3 transfer: op completes; go to INSN.
- The counter advances only on a nibble transfer; bubbles (i_de_nib_vld=0) hold state.
- Output register:
  - Loads on the same edge as the completing nibble. Latency: last nibble sampled at edge N gives o_de_op_vld=1 after edge N.
  - Output fields are stable while o_de_op_vld=1 and no transfer has occurred.
  - Output fields are don't-care but must not be X-propagating when o_de_op_vld=0; the value loaded at completion stands.
- Back-pressure: o_de_nib_rdy = !(completing nibble position && o_de_op_vld && !i_de_op_acp). Non-final nibbles are always accepted, so the next instruction's assembly overlaps a held op.
- Simultaneous completion and transfer: the output register reloads with the new op and o_de_op_vld stays 1. Full throughput is one op per 4 cycles without immediate, 8 with immediate.
- Transfer without completion: o_de_op_vld clears on the next edge.
- Flush (highest priority):
  - Next edge: FSM to INSN, counter 0, o_de_op_vld=0.
  - Any nibble presented in the flush cycle is dropped.
  - o_de_nib_rdy is 1 during flush.
- Reset values: FSM INSN, counter 0, o_de_op_vld=0, o_de_op_imm_vld=0, o_de_op_imm=0, o_de_op_ill=0, o_de_nib_rdy=1. Fields opc/a/b/c reset to 0.
- Reset mid-instruction or mid-immediate discards all partial state, with no residual op.

Optional Feature:
- Macro IDLI_DE_ILLEGAL_EN.
- Defined:
  - Opcode 4'hF decodes as illegal: o_de_op_ill=1 with o_de_op_vld=1.
  - The immediate is never collected for an illegal op, even if B == IMM_REG.
  - Execution treats the op as a trap.
- Undefined:
  - Opcode 4'hF is an ordinary opcode.
  - o_de_op_ill is constant 0.

Test Plan:
- Reset, then nibbles 4,3,2,1 on consecutive cycles with acp=1 -> one cycle later o_de_op_vld=1, opc=1, a=2, b=3, c=4, imm_vld=0.
- Instruction 16'h52F7 then imm nibbles D,C,B,A -> single op, opc=5, a=2, b=F, c=7, imm_vld=1, imm=16'hABCD; o_de_op_vld only after the 8th nibble.
- Op held with acp=0 while the next instruction's nibbles 0-2 arrive -> those are accepted; o_de_nib_rdy=0 at nibble 3 until acp=1. In the acp cycle, the first op transfers and the second loads with no gap.
- Continuous stream of 3 non-immediate ops with acp=1 -> o_de_op_vld asserted at cycles 4, 8, 12 after the first nibble; no dropped nibbles.
- Flush after 2 nibbles of an instruction while a held op is valid -> o_de_op_vld=0 next cycle; subsequent 4 nibbles form a correct fresh op.
- With IDLI_DE_ILLEGAL_EN: instruction 16'hF0F0 -> o_de_op_ill=1, imm_vld=0, next nibble treated as a new instruction. Without the macro: imm collected, ill=0.
